// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the adder, the result stage and the ALU result consumer.
// The stage takes the slave view; the adder/consumer side takes the master view.
interface alu_result_stage_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Sub;
  logic [WIDTH-1:0] Sum;
  logic             CarryOut;
  logic             In_valid;
  logic             In_ready;
  logic             Out_valid;
  logic             Out_ready;
  logic [WIDTH-1:0] Result;
  logic             Flag_Z;
  logic             Flag_N;
  logic             Flag_C;
  logic             Flag_V;
  logic             Sticky_V;
  logic             Clr_Sticky;
  logic [1:0]       Count;

  modport master (
    output A, B, Sub, Sum, CarryOut, In_valid, Out_ready, Clr_Sticky,
    input  In_ready, Out_valid, Result, Flag_Z, Flag_N, Flag_C, Flag_V, Sticky_V, Count
  );

  modport slave (
    input  A, B, Sub, Sum, CarryOut, In_valid, Out_ready, Clr_Sticky,
    output In_ready, Out_valid, Result, Flag_Z, Flag_N, Flag_C, Flag_V, Sticky_V, Count
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered result stage behind the ripple adder: computes Z/N/C/V at capture time
// and buffers results in a 2-entry FIFO with a sticky signed-overflow flag.
module alu_result_stage #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_result_stage_if.slave   bus
);
  localparam int MSB = WIDTH - 1;

  typedef struct packed {
    logic             c;
    logic             v;
    logic             n;
    logic             z;
    logic [WIDTH-1:0] sum;
  } entry_t;

  entry_t           entry_q [2];
  entry_t           entry_new;
  logic             head_q;
  logic             tail_q;
  logic [1:0]       count_q;
  logic             sticky_q;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] bx;

  // Operand B as the adder actually saw it, so V matches the real addition.
  always_comb begin
    bx            = bus.B ^ {WIDTH{bus.Sub}};
    entry_new.sum = bus.Sum;
    entry_new.z   = (bus.Sum == '0);
    entry_new.n   = bus.Sum[MSB];
    entry_new.c   = bus.CarryOut;
    entry_new.v   = (bus.A[MSB] == bx[MSB]) && (bus.Sum[MSB] != bus.A[MSB]);
  end

  assign bus.In_ready  = (count_q < 2'd2);
  assign bus.Out_valid = (count_q != 2'd0);
  assign push          = bus.In_valid && bus.In_ready;
  assign pop           = bus.Out_valid && bus.Out_ready;

  assign bus.Result   = entry_q[head_q].sum;
  assign bus.Flag_Z   = entry_q[head_q].z;
  assign bus.Flag_N   = entry_q[head_q].n;
  assign bus.Flag_C   = entry_q[head_q].c;
  assign bus.Flag_V   = entry_q[head_q].v;
  assign bus.Sticky_V = sticky_q;
  assign bus.Count    = count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      count_q    <= 2'd0;
      sticky_q   <= 1'b0;
    end else begin
      if (push) begin
        entry_q[tail_q] <= entry_new;
        tail_q          <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      // A new overflow outranks a clear arriving in the same cycle.
      sticky_q <= (sticky_q && !bus.Clr_Sticky) || (push && entry_new.v);
    end
  end
endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized scoreboard bench for alu_result_stage: expected results are queued on
// accepted pushes and checked by an independent monitor when the head is consumed.
module tb_alu_result_stage;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_result_stage_if #(.WIDTH(8)) bus();
  alu_result_stage #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
  } exp_t;

  exp_t       sb[$];
  bit         sticky_m;
  int         checks;
  int         errors;
  bit         stall_prev;
  logic [11:0] held;
  exp_t       mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: what the adder and flags mean arithmetically, not bitwise.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic sub);
    exp_t e;
    int sa, sbv, sr, ur;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    sr  = sub ? sa - sbv : sa + sbv;
    ur  = sub ? int'(a) - int'(b) : int'(a) + int'(b);
    e.res = ur[7:0];
    e.z   = (e.res == 8'd0);
    e.n   = (e.res >= 8'd128);
    e.c   = sub ? (a >= b) : (ur > 255);
    e.v   = (sr > 127) || (sr < -128);
    return e;
  endfunction

  // Monitor: checks occupancy/handshake outputs and pops the scoreboard on each consume.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("count", {30'd0, bus.Count}, sb.size());
      chk("in_ready", {31'd0, bus.In_ready}, {31'd0, sb.size() < 2});
      chk("out_valid", {31'd0, bus.Out_valid}, {31'd0, sb.size() > 0});
      chk("sticky_v", {31'd0, bus.Sticky_V}, {31'd0, sticky_m});
      if (stall_prev)
        chk("stall_hold", {20'd0, bus.Result, bus.Flag_Z, bus.Flag_N, bus.Flag_C, bus.Flag_V},
            {20'd0, held});
      if (bus.Out_valid && bus.Out_ready) begin
        if (sb.size() == 0) begin
          chk("pop_empty_sb", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("result", {24'd0, bus.Result}, {24'd0, mon_e.res});
          chk("flags_zncv", {28'd0, bus.Flag_Z, bus.Flag_N, bus.Flag_C, bus.Flag_V},
              {28'd0, mon_e.z, mon_e.n, mon_e.c, mon_e.v});
        end
      end
      stall_prev = bus.Out_valid && !bus.Out_ready;
      held = {bus.Result, bus.Flag_Z, bus.Flag_N, bus.Flag_C, bus.Flag_V};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic sub, input logic ordy, input logic clr);
    exp_t e;
    bit pushed_v;
    e = model(a, b, sub);
    @(posedge clk); #1;
    bus.In_valid   = v;
    bus.A          = a;
    bus.B          = b;
    bus.Sub        = sub;
    bus.Sum        = e.res;
    bus.CarryOut   = e.c;
    bus.Out_ready  = ordy;
    bus.Clr_Sticky = clr;
    @(negedge clk); #1;
    pushed_v = 1'b0;
    if (rst_n && bus.In_valid && bus.In_ready) begin
      sb.push_back(e);
      pushed_v = e.v;
    end
    if (rst_n)
      sticky_m = (sticky_m && !clr) || pushed_v;
  endtask

  task automatic idle(input logic ordy, input logic clr);
    cycle(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), ordy, clr);
  endtask

  // Reset with live handshake inputs: nothing may be accepted or consumed.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n         = 1'b0;
    bus.In_valid  = 1'b1;
    bus.Out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    sticky_m = 1'b0;
    chk("rst_count", {30'd0, bus.Count}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.Out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.In_ready}, 32'd1);
    chk("rst_result", {24'd0, bus.Result}, 32'd0);
    chk("rst_flags", {28'd0, bus.Flag_Z, bus.Flag_N, bus.Flag_C, bus.Flag_V}, 32'd0);
    chk("rst_sticky", {31'd0, bus.Sticky_V}, 32'd0);
    bus.In_valid  = 1'b0;
    bus.Out_ready = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; sticky_m = 1'b0; stall_prev = 1'b0; held = '0;
    rst_n = 1'b0;
    bus.In_valid = 1'b0; bus.A = '0; bus.B = '0; bus.Sub = 1'b0; bus.Sum = '0;
    bus.CarryOut = 1'b0; bus.Out_ready = 1'b0; bus.Clr_Sticky = 1'b0;
    repeat (3) @(posedge clk);
    do_reset();

    cycle(1'b1, 8'h64, 8'h32, 1'b0, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    cycle(1'b1, 8'h05, 8'h05, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    cycle(1'b1, 8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 1'b0);

    cycle(1'b1, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);

    cycle(1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b1);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);

    cycle(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    do_reset();

    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
    for (int i = 0; i < 4; i++)
      idle(1'b1, 1'b0);
    chk("drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Registered output stage directly downstream of the 8-bit ripple carry adder/subtractor. It captures the adder operands, Sub control, Sum and CarryOut, and computes the Z/N/C/V status flags. Results are buffered in a 2-entry FIFO behind a valid/ready handshake, so the ALU output consumer can apply backpressure without stalling the combinational datapath mid-result. A sticky overflow flag is kept for software polling.

Parameters:
WIDTH, 8, datapath width; must match the adder width; MSB index is WIDTH-1.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
A  input  WIDTH  adder operand A, as presented to the adder
B  input  WIDTH  adder operand B, before Sub inversion
Sub  input  1  0 = add, 1 = subtract
Sum  input  WIDTH  adder Sum output
CarryOut  input  1  adder carry out
In_valid  input  1  A/B/Sub/Sum/CarryOut valid this cycle
In_ready  output  1  stage can accept an entry this cycle
Out_valid  output  1  Result/flags at head are valid
Out_ready  input  1  consumer accepts head this cycle
Result  output  WIDTH  head entry Sum
Flag_Z  output  1  head: Result == 0
Flag_N  output  1  head: Result[WIDTH-1]
Flag_C  output  1  head: raw CarryOut (for Sub=1, 1 means no borrow)
Flag_V  output  1  head: signed overflow
Sticky_V  output  1  set when any accepted entry had V=1
Clr_Sticky  input  1  clears Sticky_V
Count  output  2  entries held (0..2)

Behaviour:
- Reset (rst_n low at a clock edge): count=0, both entries cleared, Sticky_V=0. Result and all Flag_* read 0, Out_valid=0, Count=0. In_ready=1 as soon as count=0. Reset mid-transfer discards all held entries and does not complete any handshake.
- Push = In_valid && In_ready. Pop = Out_valid && Out_ready.
- In_ready = (count < 2). It is combinational from the count register only and never depends on Out_ready. When full, no push occurs even if a pop happens in the same cycle.
- Out_valid = (count > 0). Result and flags always show the head entry and are held stable while Out_valid=1 and Out_ready=0.
- Flags are computed at push time and stored with the entry:
  - Bx = B XOR {WIDTH{Sub}}
  - V = (A[MSB] == Bx[MSB]) && (Sum[MSB] != A[MSB])
  - Z = (Sum == 0)
  - N = Sum[MSB]
  - C = CarryOut
- Latency: a push into an empty stage gives Out_valid=1 with that data on the next cycle. There is no combinational bypass from inputs to outputs.
- Ordering is strict FIFO. Push and pop in the same cycle at count=1: count stays 1, the new entry becomes head on the next cycle.
- Count updates:
  - push only: +1
  - pop only: −1
  - both: unchanged
  - neither: unchanged
- Pop at count=0 cannot occur (Out_valid=0). Push at count=2 cannot occur (In_ready=0). Input fields are ignored when In_valid=0.
- Sticky_V: next = (Sticky_V && !Clr_Sticky) || (push && V). If a set and a clear occur in the same cycle, the set wins.
- Storage: two entry registers plus head/tail pointers that wrap modulo 2. Each entry holds WIDTH+4 bits.

Test Plan:
- Add overflow: A=0x64, B=0x32, Sub=0, Sum=0x96, CarryOut=0, Out_ready=1. Next cycle: Out_valid=1, Result=0x96, N=1, V=1, Z=0, C=0. Sticky_V=1.
- Subtract to zero: A=0x05, B=0x05, Sub=1, Sum=0x00, CarryOut=1. Next cycle: Z=1, C=1, N=0, V=0.
- Signed sub overflow: A=0x80, B=0x01, Sub=1, Sum=0x7F, CarryOut=1. Next cycle: V=1, N=0, Z=0.
- Backpressure: Out_ready=0, In_valid=1 for 3 cycles with Sum=0x11, 0x22, 0x33. Required: Count goes 1 then 2, In_ready=0 on the 3rd cycle and 0x33 is not accepted. Then Out_ready=1 pops 0x11 and then 0x22 in order, with Result held stable while stalled.
- Simultaneous push/pop at count=1: Count stays 1 and the next head is the newly pushed entry. Clr_Sticky=1 in the same cycle as a push with V=1 leaves Sticky_V=1.
- Reset mid-operation: with Count=2 and Sticky_V=1, drive rst_n=0 for one edge. Required: Count=0, Out_valid=0, Result=0, all flags 0, Sticky_V=0, In_ready=1.
